// File: rtl/twf_gen.sv
// Streaming twiddle-factor generator: emits W_N^(step*i), i = 0..len-1, from a
// quarter-wave cosine ROM plus quadrant symmetry, optionally conjugated.
module twf_gen #(
   parameter  int unsigned N_FFT = 512,
   parameter  int unsigned TW_W  = 9,
   parameter  int unsigned FRAC  = 7,
   localparam int unsigned LOG2N = $clog2(N_FFT)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [LOG2N-1:0]       step,
   input  logic [LOG2N:0]         len,
   input  logic                   inverse,
   input  logic                   out_ready,
   output logic signed [TW_W-1:0] tw_re,
   output logic signed [TW_W-1:0] tw_im,
   output logic                   tw_valid,
   output logic                   tw_last,
   output logic                   busy
);

   localparam int unsigned LW = LOG2N + 1;
   localparam int unsigned OW = LOG2N - 2;
   localparam int unsigned RW = LOG2N - 1;
   localparam int unsigned QN = N_FFT / 4;

   // round(2^FRAC * cos(2*pi*j/N_FFT)) via a Q30 Taylor series, evaluated at elaboration
   function automatic logic signed [TW_W-1:0] rom_val(int unsigned j);
      longint x, x2, term, acc;
      x    = (longint'(j) * 64'sd6746518852) / longint'(N_FFT);
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      acc  = term;
      for (int k = 1; k <= 12; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
         acc  = acc + term;
      end
      return TW_W'(((acc <<< FRAC) + (64'sd1 <<< 29)) >>> 30);
   endfunction

   logic signed [TW_W-1:0] rom [0:QN];

   for (genvar j = 0; j <= int'(QN); j++) begin : g_rom
      localparam logic signed [TW_W-1:0] CV = rom_val(j);
      assign rom[j] = CV;
   end

   logic                   busy_q, busy_d;
   logic [LOG2N-1:0]       step_q, step_d;
   logic [LW-1:0]          len_q, len_d;
   logic                   inv_q, inv_d;
   logic [LOG2N-1:0]       e_q, e_d;
   logic [LW-1:0]          cnt_q, cnt_d;

   logic                   s0_valid_q, s0_valid_d;
   logic [LOG2N-1:0]       s0_e_q, s0_e_d;
   logic                   s0_last_q, s0_last_d;
   logic                   s0_inv_q, s0_inv_d;

   logic                   s1_valid_q, s1_valid_d;
   logic signed [TW_W-1:0] s1_co_q, s1_co_d;
   logic signed [TW_W-1:0] s1_cr_q, s1_cr_d;
   logic [1:0]             s1_quad_q, s1_quad_d;
   logic                   s1_inv_q, s1_inv_d;
   logic                   s1_last_q, s1_last_d;

   logic                   tw_valid_q, tw_valid_d;
   logic signed [TW_W-1:0] tw_re_q, tw_re_d;
   logic signed [TW_W-1:0] tw_im_q, tw_im_d;
   logic                   tw_last_q, tw_last_d;

   logic                   en, accept, issue, done;
   logic [RW-1:0]          oi, ri;
   logic signed [TW_W-1:0] re_m, im_m;

   always_comb begin
      en     = ~tw_valid_q | out_ready;
      accept = start & ~busy_q & (len != '0);
      issue  = en & busy_q & (cnt_q < len_q);
      done   = tw_valid_q & out_ready & tw_last_q;
   end

   // sequence control: latch on accept, advance exponent and count per issued beat
   always_comb begin
      busy_d = busy_q;
      step_d = step_q;
      len_d  = len_q;
      inv_d  = inv_q;
      e_d    = e_q;
      cnt_d  = cnt_q;
      if (accept) begin
         busy_d = 1'b1;
         step_d = step;
         len_d  = len;
         inv_d  = inverse;
         e_d    = '0;
         cnt_d  = '0;
      end else begin
         if (done) busy_d = 1'b0;
         if (issue) begin
            e_d   = e_q + step_q;
            cnt_d = cnt_q + LW'(1);
         end
      end
   end

   always_comb begin
      s0_valid_d = s0_valid_q;
      s0_e_d     = s0_e_q;
      s0_last_d  = s0_last_q;
      s0_inv_d   = s0_inv_q;
      if (en) begin
         s0_valid_d = issue;
         if (issue) begin
            s0_e_d    = e_q;
            s0_last_d = (cnt_q == len_q - LW'(1));
            s0_inv_d  = inv_q;
         end
      end
   end

   // quadrant split: offset into the quarter wave and its complement
   always_comb begin
      oi = RW'(s0_e_q[OW-1:0]);
      ri = RW'(QN) - oi;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_co_d    = s1_co_q;
      s1_cr_d    = s1_cr_q;
      s1_quad_d  = s1_quad_q;
      s1_inv_d   = s1_inv_q;
      s1_last_d  = s1_last_q;
      if (en) begin
         s1_valid_d = s0_valid_q;
         if (s0_valid_q) begin
            s1_co_d   = rom[oi];
            s1_cr_d   = rom[ri];
            s1_quad_d = s0_e_q[LOG2N-1 -: 2];
            s1_inv_d  = s0_inv_q;
            s1_last_d = s0_last_q;
         end
      end
   end

   always_comb begin
      unique case (s1_quad_q)
         2'd0:    begin re_m =  s1_co_q; im_m = -s1_cr_q; end
         2'd1:    begin re_m = -s1_cr_q; im_m = -s1_co_q; end
         2'd2:    begin re_m = -s1_co_q; im_m =  s1_cr_q; end
         default: begin re_m =  s1_cr_q; im_m =  s1_co_q; end
      endcase
   end

   always_comb begin
      tw_valid_d = tw_valid_q;
      tw_re_d    = tw_re_q;
      tw_im_d    = tw_im_q;
      tw_last_d  = tw_last_q;
      if (en) begin
         tw_valid_d = s1_valid_q;
         tw_last_d  = s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            tw_re_d = re_m;
            tw_im_d = s1_inv_q ? -im_m : im_m;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q     <= 1'b0;
         step_q     <= '0;
         len_q      <= '0;
         inv_q      <= 1'b0;
         e_q        <= '0;
         cnt_q      <= '0;
         s0_valid_q <= 1'b0;
         s0_e_q     <= '0;
         s0_last_q  <= 1'b0;
         s0_inv_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_co_q    <= '0;
         s1_cr_q    <= '0;
         s1_quad_q  <= '0;
         s1_inv_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         tw_valid_q <= 1'b0;
         tw_re_q    <= '0;
         tw_im_q    <= '0;
         tw_last_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         step_q     <= step_d;
         len_q      <= len_d;
         inv_q      <= inv_d;
         e_q        <= e_d;
         cnt_q      <= cnt_d;
         s0_valid_q <= s0_valid_d;
         s0_e_q     <= s0_e_d;
         s0_last_q  <= s0_last_d;
         s0_inv_q   <= s0_inv_d;
         s1_valid_q <= s1_valid_d;
         s1_co_q    <= s1_co_d;
         s1_cr_q    <= s1_cr_d;
         s1_quad_q  <= s1_quad_d;
         s1_inv_q   <= s1_inv_d;
         s1_last_q  <= s1_last_d;
         tw_valid_q <= tw_valid_d;
         tw_re_q    <= tw_re_d;
         tw_im_q    <= tw_im_d;
         tw_last_q  <= tw_last_d;
      end
   end

   assign tw_re    = tw_re_q;
   assign tw_im    = tw_im_q;
   assign tw_valid = tw_valid_q;
   assign tw_last  = tw_last_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_twf_gen.sv
// Bench for twf_gen: directed vector table, multi-cycle corner sequences and
// randomized sequences against a trigonometric reference model.
module tb_twf_gen;

   localparam int  N    = 512;
   localparam real PI   = 3.14159265358979323846;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              start = 1'b0;
   logic [8:0]        step = '0;
   logic [9:0]        len = '0;
   logic              inverse = 1'b0;
   logic              out_ready = 1'b1;
   logic signed [8:0] tw_re, tw_im;
   logic              tw_valid, tw_last, busy;

   twf_gen #(.N_FFT(512), .TW_W(9), .FRAC(7)) dut (
      .clk(clk), .rstn(rstn), .start(start), .step(step), .len(len),
      .inverse(inverse), .out_ready(out_ready), .tw_re(tw_re), .tw_im(tw_im),
      .tw_valid(tw_valid), .tw_last(tw_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]      step;
      logic [9:0]      len;
      logic            inv;
      logic [3:0]      stall;
      logic [7:0][8:0] re;
      logic [7:0][8:0] im;
   } vec_t;

   vec_t vecs [5];
   int   nvec = 0;
   int   checks = 0;
   int   errors = 0;

   int cap_re[$], cap_im[$], cap_last[$], cap_t[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int rnd(real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   // W = cos(theta) - j sin(theta), theta = 2*pi*e/N, scaled by 128
   task automatic model(input int e, input bit inv, output int re, output int im);
      real th;
      th = 2.0 * PI * real'(e) / real'(N);
      re = rnd(128.0 * $cos(th));
      im = -rnd(128.0 * $sin(th));
      if (inv) im = -im;
   endtask

   task automatic add_vec(input int st, input int ln, input bit iv, input int stl,
                          input int a [8], input int b [8]);
      vecs[nvec].step  = 9'(st);
      vecs[nvec].len   = 10'(ln);
      vecs[nvec].inv   = iv;
      vecs[nvec].stall = 4'(stl);
      for (int i = 0; i < 8; i++) begin
         vecs[nvec].re[i] = 9'(a[i]);
         vecs[nvec].im[i] = 9'(b[i]);
      end
      nvec++;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_re"}, int'(tw_re), 0);
      chk({nm, "_im"}, int'(tw_im), 0);
      chk({nm, "_valid"}, int'(tw_valid), 0);
      chk({nm, "_last"}, int'(tw_last), 0);
      chk({nm, "_busy"}, int'(busy), 0);
   endtask

   // rmode 0: ready high, 1: random ready + ignored starts, 2: 3-cycle stall at stall_t
   task automatic run_seq(input int st, input int ln, input bit iv, input int rmode,
                          input int stall_t);
      int t, budget, hre, him, hlast;
      bit fin;
      cap_re.delete(); cap_im.delete(); cap_last.delete(); cap_t.delete();
      hre = 0; him = 0; hlast = 0; fin = 1'b0;
      budget = 6 * ln + 40;
      @(posedge clk); #1;
      step = 9'(st); len = 10'(ln); inverse = iv; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      t = 0;
      while (t < budget && !fin) begin
         start = 1'b0;
         case (rmode)
            1: begin
               out_ready = ($urandom_range(0, 3) != 0);
               if (busy && $urandom_range(0, 7) == 0) begin
                  start = 1'b1;
                  step = 9'($urandom_range(0, 511));
                  len = 10'($urandom_range(1, 8));
                  inverse = 1'($urandom_range(0, 1));
               end
            end
            2: begin
               out_ready = !(t >= stall_t && t < stall_t + 3);
               if (t == stall_t) begin
                  hre = int'(tw_re); him = int'(tw_im); hlast = int'(tw_last);
                  start = 1'b1; step = 9'd5; len = 10'd1;
               end else if (t > stall_t && t <= stall_t + 3) begin
                  chk("stall_hold_re", int'(tw_re), hre);
                  chk("stall_hold_im", int'(tw_im), him);
                  chk("stall_hold_last", int'(tw_last), hlast);
                  chk("stall_hold_valid", int'(tw_valid), 1);
               end
            end
            default: out_ready = 1'b1;
         endcase
         if (tw_valid && out_ready) begin
            cap_re.push_back(int'(tw_re));
            cap_im.push_back(int'(tw_im));
            cap_last.push_back(int'(tw_last));
            cap_t.push_back(t);
         end
         @(posedge clk); #1;
         t++;
         if (cap_re.size() == ln) begin
            chk("busy_fall", int'(busy), 0);
            chk("valid_after_last", int'(tw_valid), 0);
            fin = 1'b1;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk("beat_count", cap_re.size(), ln);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("idle_valid", int'(tw_valid), 0);
         chk("idle_busy", int'(busy), 0);
      end
   endtask

   initial begin
      int ra [8], ia [8];
      int ere, eim;

      ra = '{128, 126, 118, 106, 91, 71, 49, 25};
      ia = '{0, -25, -49, -71, -91, -106, -118, -126};
      add_vec(16, 8, 1'b0, 0, ra, ia);
      add_vec(16, 8, 1'b0, 4, ra, ia);
      ra = '{128, 91, 0, -91, -128, -91, 0, 91};
      ia = '{0, -91, -128, -91, 0, 91, 128, 91};
      add_vec(64, 8, 1'b0, 0, ra, ia);
      ra = '{128, 91, 0, -91, 0, 0, 0, 0};
      ia = '{0, 91, 128, 91, 0, 0, 0, 0};
      add_vec(64, 4, 1'b1, 0, ra, ia);
      ra = '{128, -99, 25, 60, 0, 0, 0, 0};
      ia = '{0, -81, 126, -113, 0, 0, 0, 0};
      add_vec(200, 4, 1'b0, 0, ra, ia);

      // reset behaviour, start ignored while held in reset
      #2 rstn = 1'b0;
      #1 chk_all_zero("reset");
      step = 9'd16; len = 10'd8; start = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_start_busy", int'(busy), 0);
         chk("rst_start_valid", int'(tw_valid), 0);
      end
      start = 1'b0;
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("post_reset_busy", int'(busy), 0);

      // directed table
      for (int v = 0; v < nvec; v++) begin
         run_seq(int'(vecs[v].step), int'(vecs[v].len), vecs[v].inv,
                 (vecs[v].stall != 0) ? 2 : 0, int'(vecs[v].stall));
         for (int i = 0; i < int'(vecs[v].len) && i < cap_re.size(); i++) begin
            chk($sformatf("v%0d_re%0d", v, i), cap_re[i], int'($signed(vecs[v].re[i])));
            chk($sformatf("v%0d_im%0d", v, i), cap_im[i], int'($signed(vecs[v].im[i])));
            chk($sformatf("v%0d_last%0d", v, i), cap_last[i], (i == int'(vecs[v].len) - 1) ? 1 : 0);
            chk($sformatf("v%0d_time%0d", v, i), cap_t[i],
                3 + i + ((vecs[v].stall != 0 && i >= 1) ? 3 : 0));
         end
      end

      // len == 0 is ignored
      @(posedge clk); #1;
      step = 9'd16; len = 10'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("len0_busy", int'(busy), 0);
         chk("len0_valid", int'(tw_valid), 0);
         @(posedge clk); #1;
      end

      // randomized sequences vs. reference model
      for (int r = 0; r < 28; r++) begin
         int st, ln;
         bit iv;
         st = (r == 0) ? 1 : int'($urandom_range(0, 511));
         ln = (r == 0) ? 512 : (r == 1) ? 1 : int'($urandom_range(1, 24));
         iv = 1'($urandom_range(0, 1));
         run_seq(st, ln, iv, 1, 0);
         for (int i = 0; i < ln && i < cap_re.size(); i++) begin
            model((st * i) % N, iv, ere, eim);
            chk($sformatf("r%0d_re%0d", r, i), cap_re[i], ere);
            chk($sformatf("r%0d_im%0d", r, i), cap_im[i], eim);
            chk($sformatf("r%0d_last%0d", r, i), cap_last[i], (i == ln - 1) ? 1 : 0);
         end
      end

      // asynchronous reset mid-sequence
      @(posedge clk); #1;
      step = 9'd16; len = 10'd8; inverse = 1'b0; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("mid_valid_before_reset", int'(tw_valid), 1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("mid_reset");
      @(negedge clk) rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("after_mid_reset_valid", int'(tw_valid), 0);
         chk("after_mid_reset_busy", int'(busy), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
